// File: rtl/music_streamer.sv
// Melody sequencer: steps a tone ROM address at an adjustable tempo and feeds
// each registered ROM entry, plus a play/rest enable, to the tone generator.
module music_streamer #(
  parameter int ADDR_WIDTH      = 10,
  parameter int LAST_ADDR       = 1023,
  parameter int CYCLES_PER_NOTE = 3125000,
  parameter int TEMPO_STEP      = 250000,
  parameter int TEMPO_MIN       = 625000,
  parameter int TEMPO_MAX       = 12500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play_pause,
  input  logic                  reverse,
  input  logic                  tempo_up,
  input  logic                  tempo_down,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_data,
  output logic [23:0]           tone_switch_period,
  output logic                  output_enable,
  output logic                  playing,
  output logic                  reversed
);

  localparam int TW = 26;

  localparam logic [ADDR_WIDTH-1:0] LAST_A   = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [TW-1:0]         T_RESET  = TW'(CYCLES_PER_NOTE);
  localparam logic signed [TW+1:0]  T_STEP   = (TW+2)'(TEMPO_STEP);
  localparam logic signed [TW+1:0]  T_MIN    = (TW+2)'(TEMPO_MIN);
  localparam logic signed [TW+1:0]  T_MAX    = (TW+2)'(TEMPO_MAX);

  typedef enum logic {PAUSED = 1'b0, PLAYING = 1'b1} state_t;

  state_t                r_state;
  logic                  r_rev;
  logic [TW-1:0]         r_tempo;
  logic [TW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [23:0]           r_tone_p1;
  logic                  r_oe_p1;

  logic                  w_adv;

  // Signed headroom keeps tempo-STEP from wrapping before the clamp.
  function automatic logic [TW-1:0] sat_tempo(input logic [TW-1:0] t,
                                              input logic up, input logic dn);
    logic signed [TW+1:0] w;
    w = signed'({2'b00, t});
    if (up && !dn)      w = w - T_STEP;
    else if (dn && !up) w = w + T_STEP;
    if (w < T_MIN)      w = T_MIN;
    else if (w > T_MAX) w = T_MAX;
    return w[TW-1:0];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic rev);
    if (rev) return (a == '0) ? LAST_A : a - ADDR_WIDTH'(1);
    else     return (a == LAST_A) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  assign w_adv = (r_state == PLAYING) && (r_cnt >= r_tempo - TW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= PAUSED;
      r_rev     <= 1'b0;
      r_tempo   <= T_RESET;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_tone_p1 <= '0;
      r_oe_p1   <= 1'b0;
    end else begin
      // p1: ROM word (valid one cycle after r_addr) registered to the generator
      r_tone_p1 <= rom_data;
      r_oe_p1   <= (r_state == PLAYING) && (rom_data != 24'd0);

      if (r_state == PLAYING) begin
        if (w_adv) begin
          r_cnt  <= '0;
          r_addr <= next_addr(r_addr, r_rev);
        end else begin
          r_cnt  <= r_cnt + TW'(1);
        end
      end

      if (play_pause) r_state <= (r_state == PLAYING) ? PAUSED : PLAYING;
      if (reverse)    r_rev   <= ~r_rev;
      r_tempo <= sat_tempo(r_tempo, tempo_up, tempo_down);
    end
  end

  assign rom_addr           = r_addr;
  assign tone_switch_period = r_tone_p1;
  assign output_enable      = r_oe_p1;
  assign playing            = (r_state == PLAYING);
  assign reversed           = r_rev;

endmodule

// File: tb/tb_music_streamer.sv
// Bench for music_streamer: a cycle model of the melody rules checked every
// cycle, plus directed scenarios with hand-computed addresses and note periods.
module tb_music_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play_pause = 1'b0, reverse = 1'b0, tempo_up = 1'b0, tempo_down = 1'b0;
  logic [2:0]  rom_addr;
  logic [23:0] rom_data = 24'd0;
  logic [23:0] tone_switch_period;
  logic        output_enable, playing, reversed;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  music_streamer #(
    .ADDR_WIDTH(3), .LAST_ADDR(7), .CYCLES_PER_NOTE(4),
    .TEMPO_STEP(1), .TEMPO_MIN(2), .TEMPO_MAX(6)
  ) dut (
    .clk(clk), .rst(rst), .play_pause(play_pause), .reverse(reverse),
    .tempo_up(tempo_up), .tempo_down(tempo_down), .rom_addr(rom_addr),
    .rom_data(rom_data), .tone_switch_period(tone_switch_period),
    .output_enable(output_enable), .playing(playing), .reversed(reversed)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_f(input logic [2:0] a);
    return (a == 3'd3) ? 24'd0 : 24'd1000 + {21'd0, a};
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  // Behavioural model: note-level rules with plain integers.
  bit          m_play = 0, m_rev = 0, m_oe = 0;
  int          m_tempo = 4, m_cnt = 0, m_addr = 0;
  logic [23:0] m_tone = 0, m_rd = 0;

  always @(posedge clk) begin
    logic [23:0] nrd;
    nrd = rom_f(3'(m_addr));
    if (rst) begin
      m_play = 0; m_rev = 0; m_tempo = 4; m_cnt = 0; m_addr = 0;
      m_tone = 0; m_oe = 0;
    end else begin
      m_tone = m_rd;
      m_oe   = m_play && (m_rd != 0);
      if (m_play) begin
        if (m_cnt + 1 >= m_tempo) begin
          m_cnt  = 0;
          m_addr = m_rev ? (m_addr + 7) % 8 : (m_addr + 1) % 8;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      if (tempo_up && !tempo_down)      m_tempo = (m_tempo - 1 < 2) ? 2 : m_tempo - 1;
      else if (tempo_down && !tempo_up) m_tempo = (m_tempo + 1 > 6) ? 6 : m_tempo + 1;
      if (play_pause) m_play = !m_play;
      if (reverse)    m_rev  = !m_rev;
    end
    m_rd = nrd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rom_addr", 32'(rom_addr), 32'(m_addr));
      chk("model_tone", 32'(tone_switch_period), 32'(m_tone));
      chk("model_oe", 32'(output_enable), 32'(m_oe));
      chk("model_playing", 32'(playing), 32'(m_play));
      chk("model_reversed", 32'(reversed), 32'(m_rev));
    end
  end

  task automatic pulse(input logic pp, input logic rv, input logic up, input logic dn);
    play_pause = pp; reverse = rv; tempo_up = up; tempo_down = dn;
    @(negedge clk);
    play_pause = 0; reverse = 0; tempo_up = 0; tempo_down = 0;
  endtask

  // Cycles until rom_addr next changes; expiry counts as a failed check.
  task automatic next_adv(output int n);
    logic [2:0] a;
    a = rom_addr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rom_addr == a && n < 40);
    if (rom_addr == a) chk("advance_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_addr(input logic [2:0] a);
    int n;
    for (int k = 0; k < 10; k++) begin
      next_adv(n);
      if (rom_addr == a) return;
    end
    chk("wait_addr_timeout", 32'(rom_addr), 32'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    // 1: idle after reset
    repeat (20) @(negedge clk);
    chk("idle_addr", 32'(rom_addr), 32'd0);
    chk("idle_oe", 32'(output_enable), 32'd0);
    chk("idle_playing", 32'(playing), 32'd0);
    chk("idle_tone", 32'(tone_switch_period), 32'd1000);

    // 2: play forward at tempo 4, rest at addr 3, wrap after 7
    pulse(1, 0, 0, 0);
    chk("play_on", 32'(playing), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      next_adv(n);
      chk("fwd_period", 32'(n), (i == 4) ? 32'd2 : 32'd4);
      chk("fwd_addr", 32'(rom_addr), 32'(i % 8));
      if (i == 3) begin
        repeat (2) @(negedge clk);
        chk("rest_oe", 32'(output_enable), 32'd0);
        chk("rest_tone", 32'(tone_switch_period), 32'd0);
      end
      if (i == 5) begin
        chk("tone_addr4", 32'(tone_switch_period), 32'd1003 + 32'd1);
        chk("oe_addr4", 32'(output_enable), 32'd1);
      end
    end

    // 3: reverse at addr 2
    wait_addr(3'd2);
    pulse(0, 1, 0, 0);
    chk("rev_on", 32'(reversed), 32'd1);
    next_adv(n); chk("rev_addr1", 32'(rom_addr), 32'd1);
    next_adv(n); chk("rev_addr0", 32'(rom_addr), 32'd0);
    next_adv(n); chk("rev_addr7", 32'(rom_addr), 32'd7);
    next_adv(n); chk("rev_addr6", 32'(rom_addr), 32'd6);
    pulse(0, 1, 0, 0);
    chk("rev_off", 32'(reversed), 32'd0);
    next_adv(n); chk("fwd_again", 32'(rom_addr), 32'd7);

    // 4: tempo saturation both ways, then simultaneous up+down
    pulse(0, 0, 1, 0); pulse(0, 0, 1, 0); pulse(0, 0, 1, 0);
    next_adv(n);
    next_adv(n); chk("fast_period", 32'(n), 32'd2);
    next_adv(n); chk("fast_period2", 32'(n), 32'd2);
    for (int k = 0; k < 5; k++) pulse(0, 0, 0, 1);
    next_adv(n);
    next_adv(n); chk("slow_period", 32'(n), 32'd6);
    pulse(0, 0, 1, 1);
    next_adv(n);
    next_adv(n); chk("updown_period", 32'(n), 32'd6);
    pulse(0, 0, 1, 0); pulse(0, 0, 1, 0);

    // 5: pause with counter 2 at addr 5, resume two cycles from advance
    wait_addr(3'd5);
    @(negedge clk);
    pulse(1, 0, 0, 0);
    chk("paused", 32'(playing), 32'd0);
    repeat (12) @(negedge clk);
    chk("pause_hold_addr", 32'(rom_addr), 32'd5);
    chk("pause_oe", 32'(output_enable), 32'd0);
    pulse(1, 0, 0, 0);
    chk("resume_addr_a", 32'(rom_addr), 32'd5);
    @(negedge clk);
    chk("resume_addr_b", 32'(rom_addr), 32'd5);
    @(negedge clk);
    chk("resume_adv", 32'(rom_addr), 32'd6);

    // 6: reset mid-play, reversed, tempo 2
    pulse(0, 1, 0, 0); pulse(0, 0, 1, 0); pulse(0, 0, 1, 0);
    wait_addr(3'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_reversed", 32'(reversed), 32'd0);
    chk("rst_oe", 32'(output_enable), 32'd0);
    chk("rst_tone", 32'(tone_switch_period), 32'd0);
    pulse(1, 0, 0, 0);
    next_adv(n);
    chk("rst_tempo_period", 32'(n), 32'd4);
    chk("rst_tempo_addr", 32'(rom_addr), 32'd1);

    // simultaneous play_pause and reverse
    pulse(1, 1, 0, 0);
    chk("pp_rev_playing", 32'(playing), 32'd0);
    chk("pp_rev_reversed", 32'(reversed), 32'd1);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/music_streamer.md
Name: music_streamer

Overview:
- Sequences a stored melody into the tone generator at a fixed, adjustable tempo.
- Steps an address through an external synchronous tone ROM and registers each entry onto tone_switch_period.
- Drives the tone generator's output_enable from its play/pause state.
- Sits directly upstream of tone_generator; user pulses come from the board's debounce/edge-detect chain.

Parameters:
- ADDR_WIDTH, 10, width of the ROM address.
- LAST_ADDR, 1023, final valid ROM address (wrap point).
- CYCLES_PER_NOTE, 3125000, reset tempo in clk cycles per ROM entry (1/40 s at 125 MHz).
- TEMPO_STEP, 250000, change in cycles per tempo_up/tempo_down pulse.
- TEMPO_MIN, 625000, lower saturation limit of tempo (fastest).
- TEMPO_MAX, 12500000, upper saturation limit of tempo (slowest).

Ports:
- clk  in  1  system clock (125 MHz).
- rst  in  1  synchronous, active-high reset.
- play_pause  in  1  one-cycle pulse; toggles PAUSED/PLAYING.
- reverse  in  1  one-cycle pulse; toggles playback direction.
- tempo_up  in  1  one-cycle pulse; faster (tempo -= TEMPO_STEP).
- tempo_down  in  1  one-cycle pulse; slower (tempo += TEMPO_STEP).
- rom_addr  out  ADDR_WIDTH  tone ROM read address.
- rom_data  in  24  ROM output; valid the cycle after rom_addr is presented.
- tone_switch_period  out  24  registered period to tone_generator.
- output_enable  out  1  enable to tone_generator.
- playing  out  1  status LED; 1 in PLAYING.
- reversed  out  1  status LED; 1 when direction is reverse.

Behaviour:
- Reset values: state PAUSED, addr 0, direction forward, tempo CYCLES_PER_NOTE, note counter 0, tone_switch_period 0, output_enable 0, playing 0, reversed 0.
- Reset has priority over all pulses. Reset mid-play returns every register to its reset value on the next edge.
- rom_addr is the addr register, driven directly from it.
- tone_switch_period <= rom_data every cycle in both states.
  - Latency from an addr register update to the new tone is 2 cycles.
- output_enable is a registered output:
  - Condition: state==PLAYING and rom_data != 0.
  - A zero ROM entry is a rest.
  - output_enable is updated in the same cycle as tone_switch_period.
- State machine, PAUSED <-> PLAYING:
  - A play_pause pulse toggles the state, effective next cycle.
  - playing reflects the state.
- In PLAYING, the note counter increments each cycle.
  - When counter >= tempo-1: counter <= 0 and addr advances.
  - The >= comparison makes a tempo reduction below the current count advance on the next cycle.
- Address advance:
  - Forward: addr+1; LAST_ADDR wraps to 0.
  - Reverse: addr-1; 0 wraps to LAST_ADDR.
- In PAUSED, counter and addr hold. Resume continues from the held count with no restart.
- reverse toggles direction in either state and applies to the next advance.
  - If reverse coincides with an advance, the advance uses the old direction.
- Tempo updates:
  - tempo_up: tempo <= max(tempo-TEMPO_STEP, TEMPO_MIN).
  - tempo_down: tempo <= min(tempo+TEMPO_STEP, TEMPO_MAX).
  - Saturation arithmetic uses at least 25 bits so there is no underflow or overflow.
  - tempo_up and tempo_down in the same cycle: tempo unchanged.
  - Tempo pulses are accepted in both states.
- Simultaneous play_pause and reverse: both take effect.
- Inputs are single-cycle pulses. A held-high input toggles or steps every cycle; upstream must edge-detect.

Test Plan:
All tests use ADDR_WIDTH=3, LAST_ADDR=7, CYCLES_PER_NOTE=4, TEMPO_STEP=1, TEMPO_MIN=2, TEMPO_MAX=6. The ROM model has 1-cycle latency, data=1000+addr, except addr 3 = 0.
1. Reset then idle 20 cycles -> rom_addr=0, output_enable=0, playing=0; tone_switch_period=1000 after 1 cycle.
2. play_pause pulse -> playing=1 next cycle; rom_addr 0,1,2,... every 4 cycles; tone_switch_period follows 2 cycles after each step; output_enable=0 while addr 3 plays; after 7 wraps to 0.
3. reverse pulse at addr 2 -> next advances 1,0,7,6; reversed=1; second reverse restores forward.
4. Three tempo_up pulses -> advance every 2 cycles (saturates at 2). Then five tempo_down -> every 6 cycles (saturates at 6). Simultaneous up+down -> period unchanged.
5. Pause mid-note with counter=2 at addr 5 -> addr holds 10+ cycles, output_enable=0. Resume -> advance to 6 exactly 2 cycles later at tempo 4.
6. rst asserted during PLAYING at addr 6, reversed=1, tempo 2 -> next cycle: all outputs at reset values, tempo back to 4.
